// File: rtl/pipe_pkg.sv
// Shared types and encodings for the RV32I pipeline sequencing logic.
package pipe_pkg;

   typedef enum logic {
      RUN     = 1'b0,
      MEMWAIT = 1'b1
   } state_t;

   localparam logic [1:0] FWD_RF = 2'b00;
   localparam logic [1:0] FWD_W  = 2'b01;
   localparam logic [1:0] FWD_M  = 2'b10;

   localparam logic [1:0] WB_SEL_ALU  = 2'b00;
   localparam logic [1:0] WB_SEL_LOAD = 2'b01;
   localparam logic [1:0] WB_SEL_PC4  = 2'b10;
   localparam logic [1:0] WB_SEL_IMM  = 2'b11;

   // x0 is hardwired to zero, so it can never be the source of a hazard.
   function automatic logic reg_match(input logic [4:0] rd, input logic [4:0] rs);
      return (rd != 5'd0) && (rd == rs);
   endfunction

endpackage

// File: rtl/fwd_unit.sv
// Combinational EX-stage operand forwarding select for one source operand.
module fwd_unit
   import pipe_pkg::*;
(
   input  logic [4:0] rs,
   input  logic [4:0] rd_m,
   input  logic       wren_m,
   input  logic [4:0] rd_w,
   input  logic       wren_w,
   output logic [1:0] sel
);

   // The Memory-stage result is younger than the Writeback one, so it wins.
   always_comb begin
      sel = FWD_RF;
      if (wren_m && reg_match(rd_m, rs)) begin
         sel = FWD_M;
      end else if (wren_w && reg_match(rd_w, rs)) begin
         sel = FWD_W;
      end
   end

endmodule

// File: rtl/hazard_sched.sv
// Pipeline sequencing controller: stalls, flushes, forwarding selects,
// performance counters and data-memory timeout detection.
module hazard_sched #(
   parameter logic [1:0] WB_SEL_LOAD = 2'b01,
   parameter int         MAX_WAIT    = 16,
   parameter int         CNT_W       = 32
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [4:0]       i_rs1_addr_D,
   input  logic [4:0]       i_rs2_addr_D,
   input  logic [4:0]       i_rs1_addr_E,
   input  logic [4:0]       i_rs2_addr_E,
   input  logic [4:0]       i_rd_addr_E,
   input  logic [4:0]       i_rd_addr_M,
   input  logic [4:0]       i_rd_addr_W,
   input  logic             i_rd_wren_E,
   input  logic             i_rd_wren_M,
   input  logic             i_rd_wren_W,
   input  logic [1:0]       i_wb_sel_E,
   input  logic             i_pc_sel_E,
   input  logic             i_mem_req_M,
   input  logic             i_mem_ack,
   output logic             o_stall_F,
   output logic             o_stall_D,
   output logic             o_stall_E,
   output logic             o_stall_M,
   output logic             o_flush_D,
   output logic             o_flush_E,
   output logic             o_flush_W,
   output logic [1:0]       o_fwd_a_E,
   output logic [1:0]       o_fwd_b_E,
   output logic [CNT_W-1:0] o_stall_cnt,
   output logic [CNT_W-1:0] o_flush_cnt,
   output logic             o_mem_timeout
);

   import pipe_pkg::state_t;
   import pipe_pkg::RUN;
   import pipe_pkg::MEMWAIT;
   import pipe_pkg::FWD_RF;
   import pipe_pkg::reg_match;

   localparam logic [7:0] MAX_W = 8'(MAX_WAIT);

   state_t     state;
   state_t     state_next;
   logic       mem_wait;
   logic       load_use;
   logic [7:0] wait_cnt;
   logic [1:0] fwd_a;
   logic [1:0] fwd_b;

   assign mem_wait = i_mem_req_M && !i_mem_ack;
   assign load_use = (i_wb_sel_E == WB_SEL_LOAD) && i_rd_wren_E &&
                     (reg_match(i_rd_addr_E, i_rs1_addr_D) ||
                      reg_match(i_rd_addr_E, i_rs2_addr_D));

   fwd_unit u_fwd_a (
      .rs     (i_rs1_addr_E),
      .rd_m   (i_rd_addr_M),
      .wren_m (i_rd_wren_M),
      .rd_w   (i_rd_addr_W),
      .wren_w (i_rd_wren_W),
      .sel    (fwd_a)
   );

   fwd_unit u_fwd_b (
      .rs     (i_rs2_addr_E),
      .rd_m   (i_rd_addr_M),
      .wren_m (i_rd_wren_M),
      .rd_w   (i_rd_addr_W),
      .wren_w (i_rd_wren_W),
      .sel    (fwd_b)
   );

   assign o_fwd_a_E = i_rst ? FWD_RF : fwd_a;
   assign o_fwd_b_E = i_rst ? FWD_RF : fwd_b;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state <= RUN;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         RUN:     if (mem_wait)  state_next = MEMWAIT;
         MEMWAIT: if (!mem_wait) state_next = RUN;
         default: state_next = RUN;
      endcase
   end

   // A memory wait outranks a branch, which in turn discards any load-use hazard.
   always_comb begin
      o_stall_F = 1'b0;
      o_stall_D = 1'b0;
      o_stall_E = 1'b0;
      o_stall_M = 1'b0;
      o_flush_D = 1'b0;
      o_flush_E = 1'b0;
      o_flush_W = 1'b0;
      if (!i_rst) begin
         if (mem_wait) begin
            o_stall_F = 1'b1;
            o_stall_D = 1'b1;
            o_stall_E = 1'b1;
            o_stall_M = 1'b1;
            o_flush_W = 1'b1;
         end else if (i_pc_sel_E) begin
            o_flush_D = 1'b1;
            o_flush_E = 1'b1;
         end else if (load_use) begin
            o_stall_F = 1'b1;
            o_stall_D = 1'b1;
            o_flush_E = 1'b1;
         end
      end
   end

   // Counts consecutive wait cycles, including the one that enters MEMWAIT;
   // the timeout is sticky and does not release the stall.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         wait_cnt      <= 8'd0;
         o_mem_timeout <= 1'b0;
      end else if (mem_wait) begin
         if (wait_cnt != MAX_W) begin
            wait_cnt <= wait_cnt + 8'd1;
         end
         if (wait_cnt == MAX_W - 8'd1) begin
            o_mem_timeout <= 1'b1;
         end
      end else begin
         wait_cnt <= 8'd0;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_stall_cnt <= '0;
         o_flush_cnt <= '0;
      end else begin
         if (o_stall_F && (o_stall_cnt != '1)) begin
            o_stall_cnt <= o_stall_cnt + CNT_W'(1);
         end
         if ((o_flush_D || o_flush_E) && (o_flush_cnt != '1)) begin
            o_flush_cnt <= o_flush_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_hazard_sched.sv
// Testbench for hazard_sched: directed scenarios plus randomized traffic
// checked against a rule-level model of the sequencing behaviour.
module tb_hazard_sched;

   localparam int         MAX_WAIT  = 4;
   localparam int         CNT_W     = 32;
   localparam logic [1:0] LOAD_SEL  = 2'b01;
   localparam longint     CNT_MAX   = 64'hFFFF_FFFF;

   typedef struct packed {
      logic       sf, sd, se, sm, fd, fe, fw;
      logic [1:0] fa, fb;
   } outs_t;

   logic clk = 1'b0;
   logic rst;
   logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
   logic wren_e, wren_m, wren_w;
   logic [1:0] wb_sel_e;
   logic pc_sel_e, mem_req_m, mem_ack;

   logic stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w;
   logic [1:0] fwd_a, fwd_b;
   logic [CNT_W-1:0] stall_cnt, flush_cnt;
   logic mem_timeout;

   int checks = 0;
   int passes = 0;

   longint m_stall = 0;
   longint m_flush = 0;
   int     m_run   = 0;
   logic   m_to    = 1'b0;

   outs_t act;
   assign act = '{stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w, fwd_a, fwd_b};

   always #5 clk = ~clk;

   hazard_sched #(
      .WB_SEL_LOAD (LOAD_SEL),
      .MAX_WAIT    (MAX_WAIT),
      .CNT_W       (CNT_W)
   ) dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_rs1_addr_D  (rs1_d),
      .i_rs2_addr_D  (rs2_d),
      .i_rs1_addr_E  (rs1_e),
      .i_rs2_addr_E  (rs2_e),
      .i_rd_addr_E   (rd_e),
      .i_rd_addr_M   (rd_m),
      .i_rd_addr_W   (rd_w),
      .i_rd_wren_E   (wren_e),
      .i_rd_wren_M   (wren_m),
      .i_rd_wren_W   (wren_w),
      .i_wb_sel_E    (wb_sel_e),
      .i_pc_sel_E    (pc_sel_e),
      .i_mem_req_M   (mem_req_m),
      .i_mem_ack     (mem_ack),
      .o_stall_F     (stall_f),
      .o_stall_D     (stall_d),
      .o_stall_E     (stall_e),
      .o_stall_M     (stall_m),
      .o_flush_D     (flush_d),
      .o_flush_E     (flush_e),
      .o_flush_W     (flush_w),
      .o_fwd_a_E     (fwd_a),
      .o_fwd_b_E     (fwd_b),
      .o_stall_cnt   (stall_cnt),
      .o_flush_cnt   (flush_cnt),
      .o_mem_timeout (mem_timeout)
   );

   // Expected combinational response straight from the priority rules.
   function automatic outs_t model_outs();
      outs_t o = '0;
      logic waiting, lu;
      if (rst) return o;
      if (wren_m && rd_m != 0 && rd_m == rs1_e)      o.fa = 2'b10;
      else if (wren_w && rd_w != 0 && rd_w == rs1_e) o.fa = 2'b01;
      if (wren_m && rd_m != 0 && rd_m == rs2_e)      o.fb = 2'b10;
      else if (wren_w && rd_w != 0 && rd_w == rs2_e) o.fb = 2'b01;
      waiting = mem_req_m && !mem_ack;
      lu = (wb_sel_e == LOAD_SEL) && wren_e && rd_e != 0 && (rd_e == rs1_d || rd_e == rs2_d);
      if (waiting) begin
         o.sf = 1; o.sd = 1; o.se = 1; o.sm = 1; o.fw = 1;
      end else if (pc_sel_e) begin
         o.fd = 1; o.fe = 1;
      end else if (lu) begin
         o.sf = 1; o.sd = 1; o.fe = 1;
      end
      return o;
   endfunction

   // Counter and timeout model, tracking the length of the current wait run.
   always @(posedge clk or posedge rst) begin
      outs_t e;
      if (rst) begin
         m_stall = 0; m_flush = 0; m_run = 0; m_to = 1'b0;
      end else begin
         e = model_outs();
         if (e.sf && m_stall < CNT_MAX) m_stall++;
         if ((e.fd || e.fe) && m_flush < CNT_MAX) m_flush++;
         if (mem_req_m && !mem_ack) begin
            m_run++;
            if (m_run >= MAX_WAIT) m_to = 1'b1;
         end else begin
            m_run = 0;
         end
      end
   end

   task automatic set_idle();
      rs1_d = 0; rs2_d = 0; rs1_e = 0; rs2_e = 0;
      rd_e = 0; rd_m = 0; rd_w = 0;
      wren_e = 0; wren_m = 0; wren_w = 0;
      wb_sel_e = 2'b00; pc_sel_e = 0; mem_req_m = 0; mem_ack = 0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      set_idle();
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      set_idle();
      rs1_e = 5; rd_m = 5; wren_m = 1;
      rs2_d = 7; rd_e = 7; wren_e = 1; wb_sel_e = LOAD_SEL;
      pc_sel_e = 1; mem_req_m = 1; mem_ack = 0;
      #2;
      checks++;
      if (act !== outs_t'(0)) $display("[TB] FAIL reset_outs: got %b expected %b", act, outs_t'(0));
      else passes++;
      @(posedge clk); @(negedge clk);
      checks++;
      if (stall_cnt !== 0 || flush_cnt !== 0 || mem_timeout !== 1'b0)
         $display("[TB] FAIL reset_regs: got stall=%0d flush=%0d to=%b expected 0 0 0", stall_cnt, flush_cnt, mem_timeout);
      else passes++;
      @(posedge clk); #1;
      rst = 1'b0;
      set_idle();
   endtask

   task automatic test_forwarding();
      logic [4:0] tbl [6][6];
      logic [1:0] exp_a [6];
      logic [1:0] exp_b [6];
      do_reset();
      // rs1_e, rs2_e, rd_m, wren_m, rd_w, wren_w
      tbl[0] = '{5, 0, 5, 1, 5, 1}; exp_a[0] = 2'b10; exp_b[0] = 2'b00;
      tbl[1] = '{3, 0, 0, 1, 3, 1}; exp_a[1] = 2'b01; exp_b[1] = 2'b00;
      tbl[2] = '{9, 9, 9, 0, 9, 1}; exp_a[2] = 2'b01; exp_b[2] = 2'b01;
      tbl[3] = '{9, 4, 4, 1, 9, 1}; exp_a[3] = 2'b01; exp_b[3] = 2'b10;
      tbl[4] = '{0, 0, 0, 1, 0, 1}; exp_a[4] = 2'b00; exp_b[4] = 2'b00;
      tbl[5] = '{7, 8, 7, 0, 8, 0}; exp_a[5] = 2'b00; exp_b[5] = 2'b00;
      for (int i = 0; i < 6; i++) begin
         rs1_e = tbl[i][0]; rs2_e = tbl[i][1];
         rd_m = tbl[i][2]; wren_m = tbl[i][3][0];
         rd_w = tbl[i][4]; wren_w = tbl[i][5][0];
         @(negedge clk);
         checks++;
         if (fwd_a !== exp_a[i]) $display("[TB] FAIL fwd_a case %0d: got %b expected %b", i, fwd_a, exp_a[i]);
         else passes++;
         checks++;
         if (fwd_b !== exp_b[i]) $display("[TB] FAIL fwd_b case %0d: got %b expected %b", i, fwd_b, exp_b[i]);
         else passes++;
         @(posedge clk); #1;
      end
      set_idle();
   endtask

   task automatic test_load_use();
      do_reset();
      wb_sel_e = LOAD_SEL; wren_e = 1; rd_e = 7; rs1_d = 3; rs2_d = 7;
      @(negedge clk);
      checks++;
      if ({stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w} !== 7'b1100010)
         $display("[TB] FAIL load_use_bubble: got %b expected 1100010",
                  {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w});
      else passes++;
      @(posedge clk); #1;
      wb_sel_e = 2'b00; wren_e = 0; rd_e = 0; rd_m = 7; wren_m = 1;
      @(negedge clk);
      checks++;
      if ({stall_f, stall_d, flush_e} !== 3'b000)
         $display("[TB] FAIL load_use_release: got %b expected 000", {stall_f, stall_d, flush_e});
      else passes++;
      checks++;
      if (stall_cnt !== 1) $display("[TB] FAIL load_use_stall_cnt: got %0d expected 1", stall_cnt);
      else passes++;
      @(posedge clk); #1;
      set_idle();
   endtask

   task automatic test_branch_over_load_use();
      do_reset();
      wb_sel_e = LOAD_SEL; wren_e = 1; rd_e = 7; rs2_d = 7; pc_sel_e = 1;
      @(negedge clk);
      checks++;
      if ({flush_d, flush_e, stall_f, stall_d} !== 4'b1100)
         $display("[TB] FAIL branch_flush: got %b expected 1100", {flush_d, flush_e, stall_f, stall_d});
      else passes++;
      @(posedge clk); #1;
      set_idle();
      @(negedge clk);
      checks++;
      if (flush_cnt !== 1 || stall_cnt !== 0)
         $display("[TB] FAIL branch_counts: got flush=%0d stall=%0d expected 1 0", flush_cnt, stall_cnt);
      else passes++;
      @(posedge clk); #1;
   endtask

   task automatic test_mem_wait();
      do_reset();
      mem_req_m = 1; mem_ack = 0; pc_sel_e = 1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if ({stall_f, stall_d, stall_e, stall_m, flush_w, flush_d, flush_e} !== 7'b1111100)
            $display("[TB] FAIL mem_wait_cycle %0d: got %b expected 1111100", i,
                     {stall_f, stall_d, stall_e, stall_m, flush_w, flush_d, flush_e});
         else passes++;
         @(posedge clk); #1;
      end
      mem_ack = 1; pc_sel_e = 0;
      @(negedge clk);
      checks++;
      if ({stall_f, stall_d, stall_e, stall_m, flush_w} !== 5'b00000)
         $display("[TB] FAIL mem_ack_release: got %b expected 00000",
                  {stall_f, stall_d, stall_e, stall_m, flush_w});
      else passes++;
      checks++;
      if (stall_cnt !== 3 || flush_cnt !== 0)
         $display("[TB] FAIL mem_wait_counts: got stall=%0d flush=%0d expected 3 0", stall_cnt, flush_cnt);
      else passes++;
      @(posedge clk); #1;
      set_idle();
   endtask

   task automatic test_timeout();
      do_reset();
      mem_req_m = 1; mem_ack = 0;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         checks++;
         if (mem_timeout !== (k > MAX_WAIT))
            $display("[TB] FAIL timeout_cycle %0d: got %b expected %b", k, mem_timeout, k > MAX_WAIT);
         else passes++;
         @(posedge clk); #1;
      end
      mem_ack = 1;
      @(negedge clk);
      checks++;
      if (mem_timeout !== 1'b1 || stall_cnt !== 6)
         $display("[TB] FAIL timeout_after_ack: got to=%b stall=%0d expected 1 6", mem_timeout, stall_cnt);
      else passes++;
      @(posedge clk); #1;
      mem_req_m = 0; mem_ack = 0;
      @(negedge clk);
      checks++;
      if (mem_timeout !== 1'b1) $display("[TB] FAIL timeout_sticky: got %b expected 1", mem_timeout);
      else passes++;
      @(posedge clk); #1;
      mem_req_m = 1;
      @(posedge clk); #3;
      rst = 1'b1;
      #1;
      checks++;
      if (act !== outs_t'(0) || stall_cnt !== 0 || flush_cnt !== 0 || mem_timeout !== 1'b0)
         $display("[TB] FAIL reset_mid_wait: got outs=%b stall=%0d flush=%0d to=%b expected 0 0 0 0",
                  act, stall_cnt, flush_cnt, mem_timeout);
      else passes++;
      @(posedge clk); #1;
      rst = 1'b0;
      set_idle();
   endtask

   task automatic test_random();
      outs_t e;
      do_reset();
      for (int n = 0; n < 400; n++) begin
         rst       = ($urandom_range(0, 99) == 0);
         rs1_d     = 5'($urandom_range(0, 3));
         rs2_d     = 5'($urandom_range(0, 3));
         rs1_e     = 5'($urandom_range(0, 3));
         rs2_e     = 5'($urandom_range(0, 3));
         rd_e      = 5'($urandom_range(0, 3));
         rd_m      = 5'($urandom_range(0, 3));
         rd_w      = 5'($urandom_range(0, 3));
         wren_e    = 1'($urandom);
         wren_m    = 1'($urandom);
         wren_w    = 1'($urandom);
         wb_sel_e  = 2'($urandom);
         pc_sel_e  = ($urandom_range(0, 4) == 0);
         mem_req_m = ($urandom_range(0, 2) == 0);
         mem_ack   = ($urandom_range(0, 2) == 0);
         @(negedge clk);
         e = model_outs();
         checks++;
         if (act !== e) $display("[TB] FAIL rand_outs %0d: got %b expected %b", n, act, e);
         else passes++;
         checks++;
         if (stall_cnt !== m_stall[CNT_W-1:0])
            $display("[TB] FAIL rand_stall_cnt %0d: got %0d expected %0d", n, stall_cnt, m_stall);
         else passes++;
         checks++;
         if (flush_cnt !== m_flush[CNT_W-1:0])
            $display("[TB] FAIL rand_flush_cnt %0d: got %0d expected %0d", n, flush_cnt, m_flush);
         else passes++;
         checks++;
         if (mem_timeout !== m_to)
            $display("[TB] FAIL rand_timeout %0d: got %b expected %b", n, mem_timeout, m_to);
         else passes++;
         @(posedge clk); #1;
      end
      rst = 1'b0;
      set_idle();
   endtask

   initial begin
      rst = 1'b1;
      set_idle();
      test_reset();
      test_forwarding();
      test_load_use();
      test_branch_over_load_use();
      test_mem_wait();
      test_timeout();
      test_random();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/hazard_sched.md
Name: hazard_sched

Overview:
- Pipeline sequencing controller for the 5-stage RV32I core with no branch prediction.
- Drives stall/enable and flush of the IF/ID, ID/EX, EX/MEM and MEM/WB registers, and generates EX-stage operand forwarding selects.
- Sequences load-use bubbles, taken-branch/jump flushes and multi-cycle data-memory waits.
- Keeps stall/flush performance counters and a memory-timeout error flag.

Parameters:
- WB_SEL_LOAD, 2'b01, wb_sel encoding meaning "write back load data".
- MAX_WAIT, 16, memory-wait cycles before o_mem_timeout sets (range 1..255).
- CNT_W, 32, performance counter width.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset, asynchronous, active-high
- i_rs1_addr_D / i_rs2_addr_D  in  5 each  source regs in Decode
- i_rs1_addr_E / i_rs2_addr_E  in  5 each  source regs in Execute
- i_rd_addr_E / i_rd_addr_M / i_rd_addr_W  in  5 each  destination regs per stage
- i_rd_wren_E / i_rd_wren_M / i_rd_wren_W  in  1 each  regfile write enable per stage
- i_wb_sel_E  in  2  write-back select of Execute instruction
- i_pc_sel_E  in  1  branch taken / jump resolved in Execute
- i_mem_req_M  in  1  load/store active in Memory stage
- i_mem_ack  in  1  data memory completes access this cycle
- o_stall_F / o_stall_D / o_stall_E / o_stall_M  out  1 each  hold PC / IF/ID / ID/EX / EX/MEM
- o_flush_D / o_flush_E / o_flush_W  out  1 each  bubble into IF/ID / ID/EX / MEM/WB
- o_fwd_a_E / o_fwd_b_E  out  2 each  00 regfile, 01 from W, 10 from M
- o_stall_cnt / o_flush_cnt  out  CNT_W each  performance counters
- o_mem_timeout  out  1  sticky error

Behaviour:
- State machine states: RUN and MEMWAIT. Reset enters RUN.
- Reset values: state RUN, counters 0, wait counter 0, o_mem_timeout 0. While i_rst is high, all stall/flush outputs are forced to 0 and fwd selects to 00.
- Stall, flush and fwd outputs are combinational from state and inputs, so they act in the same cycle with zero latency. Counters and flag are registered.
- Register x0 never matches; any address equal to 0 produces no hazard and no forward.
- Forwarding, per operand X in {rs1, rs2}:
  - 10 if rd_wren_M, rd_M != 0 and rd_M == rsX_E.
  - else 01 if rd_wren_W, rd_W != 0 and rd_W == rsX_E.
  - else 00. M has priority over W.
- Memory wait:
  - Condition: i_mem_req_M && !i_mem_ack, in RUN or MEMWAIT.
  - Response: stall_F, stall_D, stall_E, stall_M = 1 and flush_W = 1. flush_D and flush_E = 0.
  - This has highest priority; branch and load-use evaluation is suppressed.
  - RUN goes to MEMWAIT on the wait condition. MEMWAIT returns to RUN on the first cycle i_mem_ack = 1 or i_mem_req_M = 0; that cycle is a normal cycle.
- Branch flush (i_pc_sel_E = 1 and no memory wait): flush_D = flush_E = 1, no stalls. The load-use check is ignored because the D instruction is discarded.
- Load-use:
  - Condition: i_wb_sel_E == WB_SEL_LOAD, rd_wren_E, rd_E != 0, and (rd_E == rs1_D or rd_E == rs2_D).
  - Response: stall_F = stall_D = 1 and flush_E = 1, for exactly one cycle. The load then moves to M and the match clears.
- Wait counter:
  - Increments each MEMWAIT cycle and clears on leaving MEMWAIT.
  - When it reaches MAX_WAIT, o_mem_timeout sets and stays set until reset. Stalling continues; no forced release.
- o_stall_cnt: +1 on every cycle with stall_F = 1.
- o_flush_cnt: +1 on every cycle with flush_D = 1 or flush_E = 1.
- Both counters saturate at all-ones; no wrap.
- Reset asserted mid-wait: immediate return to RUN and counters cleared.

Decomposition:
- Shared package pipe_pkg holds:
  - state enum {RUN, MEMWAIT};
  - fwd select constants FWD_RF = 00, FWD_W = 01, FWD_M = 10;
  - the wb_sel encodings, including WB_SEL_LOAD.
- One sub-module, fwd_unit: purely combinational forwarding compare, instantiated once per operand.

Test Plan:
- Forwarding:
  - E.rs1 = 5, M.rd = 5 wren, W.rd = 5 wren -> fwd_a = 10.
  - M.rd = 0 wren, E.rs2 = 0 -> fwd_b = 00.
- Load-use:
  - E is a load with rd = 7, D.rs2 = 7 -> one cycle of stall_F/D = 1, flush_E = 1.
  - Next cycle all stalls 0; o_stall_cnt = 1.
- Taken branch with load-use:
  - pc_sel_E = 1 while the load-use condition is also true -> flush_D = flush_E = 1, stall_F = 0, o_flush_cnt +1.
- Memory wait:
  - mem_req_M = 1, mem_ack low for 3 cycles -> 3 cycles of stall_F/D/E/M and flush_W, pc_sel_E flush suppressed.
  - ack cycle returns to RUN; o_stall_cnt = 3.
- Timeout:
  - MAX_WAIT = 4, ack withheld for 6 cycles -> o_mem_timeout rises after the 4th wait cycle and stays high after ack.
  - Async reset mid-wait clears it, outputs 0, counters 0.
